mdu_iter: RTL and testbench



---
 rtl/mdu_pkg.sv | 40 ++++
 rtl/mdu_div_core.sv | 47 ++++
 rtl/mdu_iter.sv | 143 ++++++++++++++
 tb/tb_mdu_iter.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the iterative multiply/divide unit.
//   - 4-bit MDU operation codes
//   - default multiply/divide latencies
//   - op classification helpers (is_mul, is_div, is_macc, is_signed_op)
package mdu_pkg;

  localparam logic [3:0] MDU_NONE  = 4'd0;
  localparam logic [3:0] MDU_MULT  = 4'd1;
  localparam logic [3:0] MDU_MULTU = 4'd2;
  localparam logic [3:0] MDU_DIV   = 4'd3;
  localparam logic [3:0] MDU_DIVU  = 4'd4;
  localparam logic [3:0] MDU_MFHI  = 4'd5;
  localparam logic [3:0] MDU_MFLO  = 4'd6;
  localparam logic [3:0] MDU_MTHI  = 4'd7;
  localparam logic [3:0] MDU_MTLO  = 4'd8;
  localparam logic [3:0] MDU_MADD  = 4'd9;
  localparam logic [3:0] MDU_MADDU = 4'd10;
  localparam logic [3:0] MDU_MSUB  = 4'd11;
  localparam logic [3:0] MDU_MSUBU = 4'd12;

  localparam int unsigned MDU_MUL_CYCLES_DEF = 5;
  localparam int unsigned MDU_DIV_CYCLES_DEF = 10;

  function automatic logic is_mul(input logic [3:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU);
  endfunction

  function automatic logic is_div(input logic [3:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  function automatic logic is_macc(input logic [3:0] op);
    return (op == MDU_MADD) || (op == MDU_MADDU) || (op == MDU_MSUB) || (op == MDU_MSUBU);
  endfunction

  function automatic logic is_signed_op(input logic [3:0] op);
    return (op == MDU_MULT) || (op == MDU_DIV) || (op == MDU_MADD) || (op == MDU_MSUB);
  endfunction

endpackage

// File: rtl/mdu_div_core.sv
// mdu_div_core: combinational signed/unsigned divider.
//   dividend, divisor : WIDTH-bit operands
//   is_signed         : 1 = two's complement divide, 0 = unsigned
//   quot              : quotient, truncated toward zero
//   rem               : remainder, sign follows the dividend
//   div_by_zero       : divisor is zero (quot/rem forced to 0, caller ignores them)
// MIN / -1 yields quot = MIN, rem = 0.
module mdu_div_core #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             is_signed,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem,
  output logic             div_by_zero
);

  localparam logic [WIDTH-1:0] MinVal = {1'b1, {(WIDTH-1){1'b0}}};

  logic             neg_a, neg_b, ovf;
  logic [WIDTH-1:0] abs_a, abs_b, uq, ur;

  always_comb begin
    neg_a       = is_signed & dividend[WIDTH-1];
    neg_b       = is_signed & divisor[WIDTH-1];
    abs_a       = neg_a ? (~dividend + 1'b1) : dividend;
    abs_b       = neg_b ? (~divisor + 1'b1) : divisor;
    div_by_zero = (divisor == '0);
    ovf         = is_signed && (dividend == MinVal) && (divisor == '1);
    uq          = '0;
    ur          = '0;
    quot        = '0;
    rem         = '0;
    if (ovf) begin
      quot = MinVal;
      rem  = '0;
    end else if (!div_by_zero) begin
      // Divide magnitudes, then restore signs.
      uq   = abs_a / abs_b;
      ur   = abs_a % abs_b;
      quot = (neg_a ^ neg_b) ? (~uq + 1'b1) : uq;
      rem  = neg_a ? (~ur + 1'b1) : ur;
    end
  end

endmodule

// File: rtl/mdu_iter.sv
// mdu_iter: multi-cycle multiply/divide unit owning HI/LO for the E stage.
//   clk, reset : clock, synchronous active-high reset
//   req        : CP0 exception/interrupt request, blocks issue and mt* this cycle
//   start, op  : E-stage multi-cycle op and its mdu_pkg code
//   d1, d2     : forwarded rs / rt
//   busy       : op in flight (registered)
//   hi, lo     : architectural HI/LO
// The result is computed at issue and held in pend_*; a down-counter models the
// latency and commits pend_* to HI/LO when it reaches zero.
// Build option: define MDU_MACC_EN to enable madd/maddu/msub/msubu; otherwise
// op codes 9-12 are no-ops and the accumulate datapath is absent.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned MUL_CYCLES = MDU_MUL_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES = MDU_DIV_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned MaxCycles = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e           st_q;
  logic [CntW-1:0]  count_q;
  logic [WIDTH-1:0] hi_q, lo_q, pend_hi_q, pend_lo_q;
  logic             pend_wr_q;

  // Issue decode and result datapath
  logic               op_signed, op_ok, issue;
  logic [2*WIDTH-1:0] a_ext, b_ext, product;
  logic [WIDTH-1:0]   quot, rem;
  logic               div_by_zero;
  logic [WIDTH-1:0]   res_hi, res_lo;
  logic               res_wr;
  logic [CntW-1:0]    load_cnt;

  mdu_div_core #(
    .WIDTH (WIDTH)
  ) u_div (
    .dividend    (d1),
    .divisor     (d2),
    .is_signed   (op_signed),
    .quot        (quot),
    .rem         (rem),
    .div_by_zero (div_by_zero)
  );

`ifdef MDU_MACC_EN
  logic [2*WIDTH-1:0] acc_res;
  always_comb begin
    // Accumulate base is HI/LO as seen at issue.
    if ((op == MDU_MSUB) || (op == MDU_MSUBU)) acc_res = {hi_q, lo_q} - product;
    else                                       acc_res = {hi_q, lo_q} + product;
  end
  assign op_ok = is_mul(op) || is_div(op) || is_macc(op);
`else
  assign op_ok = is_mul(op) || is_div(op);
`endif

  always_comb begin
    op_signed = is_signed_op(op);
    a_ext     = op_signed ? {{WIDTH{d1[WIDTH-1]}}, d1} : {{WIDTH{1'b0}}, d1};
    b_ext     = op_signed ? {{WIDTH{d2[WIDTH-1]}}, d2} : {{WIDTH{1'b0}}, d2};
    // Low 2*WIDTH bits of the extended product are the exact signed/unsigned product.
    product   = a_ext * b_ext;
    issue     = (st_q == StIdle) && start && !req && op_ok;

    res_hi   = product[2*WIDTH-1:WIDTH];
    res_lo   = product[WIDTH-1:0];
    res_wr   = 1'b1;
    load_cnt = CntW'(MUL_CYCLES);
    if (is_div(op)) begin
      res_hi   = rem;
      res_lo   = quot;
      res_wr   = !div_by_zero;
      load_cnt = CntW'(DIV_CYCLES);
    end
`ifdef MDU_MACC_EN
    else if (is_macc(op)) begin
      res_hi = acc_res[2*WIDTH-1:WIDTH];
      res_lo = acc_res[WIDTH-1:0];
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q      <= StIdle;
      count_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_wr_q <= 1'b0;
    end else begin
      unique case (st_q)
        StIdle: begin
          if (issue) begin
            pend_hi_q <= res_hi;
            pend_lo_q <= res_lo;
            pend_wr_q <= res_wr;
            count_q   <= load_cnt;
            st_q      <= StRun;
          end else if (!req && (op == MDU_MTHI)) begin
            hi_q <= d1;
          end else if (!req && (op == MDU_MTLO)) begin
            lo_q <= d1;
          end
        end
        StRun: begin
          // Starts and mt* are dropped here; req does not cancel an issued op.
          count_q <= count_q - 1'b1;
          if (count_q == CntW'(1)) begin
            st_q <= StIdle;
            if (pend_wr_q) begin
              hi_q <= pend_hi_q;
              lo_q <= pend_lo_q;
            end
          end
        end
        default: st_q <= StIdle;
      endcase
    end
  end

  assign busy = (st_q == StRun);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_iter.sv
module tb_mdu_iter;
  import mdu_pkg::*;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         reset, req, start;
  logic [3:0]   op;
  logic [W-1:0] d1, d2;
  logic         busy;
  logic [W-1:0] hi, lo;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mdu_iter #(
    .WIDTH      (W),
    .MUL_CYCLES (5),
    .DIV_CYCLES (10)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .start (start),
    .op    (op),
    .d1    (d1),
    .d2    (d2),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  typedef struct {
    logic [3:0]   op;
    logic         rq;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] ehi;
    logic [W-1:0] elo;
    int           ecyc;
  } vec_t;

  vec_t tbl[20];
  vec_t exp_q[$];

  function automatic vec_t mk(input logic [3:0] o, input logic r, input logic [W-1:0] a,
                              input logic [W-1:0] b, input logic [W-1:0] eh,
                              input logic [W-1:0] el, input int c);
    vec_t v;
    v.op = o; v.rq = r; v.a = a; v.b = b; v.ehi = eh; v.elo = el; v.ecyc = c;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // One-cycle drive of an E-stage op; returns at the negedge after the issue edge.
  task automatic drive_op(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic r);
    @(negedge clk);
    op = o; d1 = a; d2 = b; req = r; start = 1'b1;
    @(negedge clk);
    op = MDU_NONE; d1 = '0; d2 = '0; req = 1'b0; start = 1'b0;
  endtask

  // Counts remaining busy cycles, pops the scoreboard and compares.
  task automatic wait_done(input string tag, input int pre);
    vec_t e;
    int cnt;
    cnt = pre;
    while (busy === 1'b1 && cnt < 200) begin
      cnt++;
      @(negedge clk);
    end
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_scoreboard: got empty queue, want an entry", tag);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_busy_cycles"}, 64'(cnt), 64'(e.ecyc));
      check({tag, "_hi"}, 64'(hi), 64'(e.ehi));
      check({tag, "_lo"}, 64'(lo), 64'(e.elo));
    end
  endtask

  task automatic apply(input string tag, input vec_t v);
    exp_q.push_back(v);
    drive_op(v.op, v.a, v.b, v.rq);
    wait_done(tag, 0);
  endtask

  initial begin
    reset = 1'b1; req = 1'b0; start = 1'b0; op = MDU_NONE; d1 = '0; d2 = '0;

    tbl[0]  = mk(MDU_MULT,  0, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 5);
    tbl[1]  = mk(MDU_DIVU,  0, 32'd7, 32'd2, 32'd1, 32'd3, 10);
    tbl[2]  = mk(MDU_DIV,   0, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 10);
    tbl[3]  = mk(MDU_MTHI,  0, 32'h12345678, 32'd0, 32'h12345678, 32'hFFFFFFFD, 0);
    tbl[4]  = mk(MDU_DIV,   0, 32'd5, 32'd0, 32'h12345678, 32'hFFFFFFFD, 10);
    tbl[5]  = mk(MDU_MULT,  1, 32'd2, 32'd3, 32'h12345678, 32'hFFFFFFFD, 0);
    tbl[6]  = mk(MDU_MTLO,  1, 32'h0000AAAA, 32'd0, 32'h12345678, 32'hFFFFFFFD, 0);
    tbl[7]  = mk(MDU_MULTU, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5);
    tbl[8]  = mk(MDU_DIV,   0, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10);
    tbl[9]  = mk(MDU_DIV,   0, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 10);
    tbl[10] = mk(MDU_MTHI,  0, 32'd0, 32'd0, 32'd0, 32'hFFFFFFFD, 0);
    tbl[11] = mk(MDU_MTLO,  0, 32'hFFFFFFFF, 32'd0, 32'd0, 32'hFFFFFFFF, 0);
`ifdef MDU_MACC_EN
    tbl[12] = mk(MDU_MADDU, 0, 32'd1, 32'd1, 32'd1, 32'd0, 5);
`else
    tbl[12] = mk(MDU_MADDU, 0, 32'd1, 32'd1, 32'd0, 32'hFFFFFFFF, 0);
`endif
    tbl[13] = mk(MDU_MTHI,  0, 32'd0, 32'd0, 32'd0, (tbl[12].elo), 0);
    tbl[14] = mk(MDU_MTLO,  0, 32'd0, 32'd0, 32'd0, 32'd0, 0);
`ifdef MDU_MACC_EN
    tbl[15] = mk(MDU_MSUB,  0, 32'd1, 32'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5);
    tbl[16] = mk(MDU_MADD,  0, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 5);
    tbl[17] = mk(4'd13,     0, 32'd9, 32'd9, 32'hFFFFFFFF, 32'hFFFFFFFD, 0);
    tbl[18] = mk(MDU_MFHI,  0, 32'd9, 32'd9, 32'hFFFFFFFF, 32'hFFFFFFFD, 0);
    tbl[19] = mk(MDU_MSUBU, 1, 32'd3, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFD, 0);
`else
    tbl[15] = mk(MDU_MSUB,  0, 32'd1, 32'd1, 32'd0, 32'd0, 0);
    tbl[16] = mk(MDU_MADD,  0, 32'hFFFFFFFF, 32'd2, 32'd0, 32'd0, 0);
    tbl[17] = mk(4'd13,     0, 32'd9, 32'd9, 32'd0, 32'd0, 0);
    tbl[18] = mk(MDU_MFHI,  0, 32'd9, 32'd9, 32'd0, 32'd0, 0);
    tbl[19] = mk(MDU_MSUBU, 0, 32'd3, 32'd3, 32'd0, 32'd0, 0);
`endif

    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_hi", 64'(hi), 64'd0);
    check("reset_lo", 64'(lo), 64'd0);

    for (int i = 0; i < 20; i++) apply($sformatf("vec%0d", i), tbl[i]);

    // Reset in the middle of a divide, with count at 3.
    apply("pre_rst_mthi", mk(MDU_MTHI, 0, 32'h55, 32'd0, 32'h55, tbl[19].elo, 0));
    drive_op(MDU_DIV, 32'd100, 32'd7, 1'b0);
    repeat (7) @(negedge clk);
    check("mid_div_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_hi", 64'(hi), 64'd0);
    check("rst_mid_lo", 64'(lo), 64'd0);
    apply("post_rst_mult", mk(MDU_MULT, 0, 32'd6, 32'd7, 32'd0, 32'd42, 5));

    // req, mthi and a new start while running must not disturb the in-flight op.
    exp_q.push_back(mk(MDU_MULTU, 0, 32'd3, 32'd4, 32'd0, 32'd12, 5));
    drive_op(MDU_MULTU, 32'd3, 32'd4, 1'b0);
    op = MDU_MTHI; d1 = 32'hDEAD; req = 1'b1; start = 1'b1;
    @(negedge clk);
    op = MDU_DIV; d1 = 32'd9; d2 = 32'd3; req = 1'b0;
    @(negedge clk);
    op = MDU_NONE; d1 = '0; d2 = '0; start = 1'b0;
    wait_done("run_disturb", 2);
    @(negedge clk);
    check("run_disturb_idle", 64'(busy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
